// File: rtl/fuzz_eval_sequencer.sv
// Shares one trapezoid membership evaluator across the 12 UP/LOW membership
// functions of the two-input interval type-2 fuzzifier, then publishes all degrees at once.
module fuzz_eval_sequencer #(
  parameter logic [383:0] TRAP_TABLE = {
    8'd0,   8'd1,   8'd51,  8'd114,  8'd0,   8'd1,   8'd51,  8'd107,
    8'd5,   8'd77,  8'd153, 8'd222,  8'd18,  8'd77,  8'd153, 8'd209,
    8'd118, 8'd179, 8'd254, 8'd255,  8'd125, 8'd179, 8'd254, 8'd255,
    8'd0,   8'd1,   8'd77,  8'd148,  8'd0,   8'd1,   8'd77,  8'd133,
    8'd31,  8'd102, 8'd179, 8'd250,  8'd46,  8'd102, 8'd179, 8'd235,
    8'd153, 8'd230, 8'd254, 8'd255,  8'd168, 8'd230, 8'd254, 8'd255},
  parameter int unsigned  TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        EN_SCLK,
  input  logic [7:0]  Input_01,
  input  logic [7:0]  Input_02,
  output logic        eval_start,
  output logic [7:0]  eval_x,
  output logic [7:0]  eval_a,
  output logic [7:0]  eval_b,
  output logic [7:0]  eval_c,
  output logic [7:0]  eval_d,
  input  logic        eval_done,
  input  logic [7:0]  eval_mu,
  output logic [47:0] FOU_UP,
  output logic [47:0] FOU_LOW,
  output logic [5:0]  Ativo_UP,
  output logic        out_valid,
  output logic        busy,
  output logic        sample_drop,
  output logic        eval_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUBLISH} state_t;

  // Entry 0 sits in the top 32 bits, so it lands in element 11 of this view.
  localparam logic [11:0][31:0] TBL = TRAP_TABLE;
  localparam logic [7:0]        TMO = 8'(TIMEOUT);

  state_t           state, state_nxt;
  logic [3:0]       k;
  logic [7:0]       timer;
  logic [7:0]       in1, in2;
  logic [11:0][7:0] shadow, shadow_nxt;
  logic [31:0]      entry;
  logic [47:0]      pub_up, pub_low;
  logic [5:0]       pub_act;
  logic             tmo, store, last;

  assign entry = TBL[4'd11 - k];
  assign last  = (k == 4'd11);
  assign tmo   = (state == WAIT) && !eval_done && (timer + 8'd1 == TMO);
  assign store = (state == WAIT) && (eval_done || tmo);

  // Shadow contents including this cycle's store, so the final slot can be
  // published on the same edge that enters PUBLISH.
  always_comb begin
    shadow_nxt = shadow;
    if (store) shadow_nxt[k] = eval_done ? eval_mu : 8'd0;
    pub_up  = '0;
    pub_low = '0;
    pub_act = '0;
    for (int j = 0; j < 6; j++) begin
      pub_up[8*j +: 8]  = shadow_nxt[2*j];
      pub_low[8*j +: 8] = shadow_nxt[2*j+1];
      pub_act[5-j]      = |shadow_nxt[2*j];
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (EN_SCLK) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (store) state_nxt = last ? PUBLISH : ISSUE;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    eval_start  = (state == ISSUE);
    out_valid   = (state == PUBLISH);
    sample_drop = EN_SCLK && busy;
    eval_x      = 8'd0;
    eval_a      = 8'd0;
    eval_b      = 8'd0;
    eval_c      = 8'd0;
    eval_d      = 8'd0;
    if (state == ISSUE || state == WAIT) begin
      eval_x = (k < 4'd6) ? in1 : in2;
      {eval_a, eval_b, eval_c, eval_d} = entry;
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      k        <= '0;
      timer    <= '0;
      in1      <= '0;
      in2      <= '0;
      shadow   <= '0;
      FOU_UP   <= '0;
      FOU_LOW  <= '0;
      Ativo_UP <= '0;
      eval_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (EN_SCLK) begin
          in1      <= Input_01;
          in2      <= Input_02;
          eval_err <= 1'b0;
          k        <= '0;
        end
        ISSUE: timer <= '0;
        WAIT: begin
          if (!eval_done) timer <= timer + 8'd1;
          if (store) begin
            shadow <= shadow_nxt;
            if (tmo) eval_err <= 1'b1;
            if (last) begin
              FOU_UP   <= pub_up;
              FOU_LOW  <= pub_low;
              Ativo_UP <= pub_act;
            end else begin
              k <= k + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_eval_sequencer.sv
// Directed bench for fuzz_eval_sequencer with a behavioural trapezoid evaluator
// whose response delay and fault behaviour are steered from the stimulus.
module tb_fuzz_eval_sequencer;
  logic        clk = 1'b0;
  logic        RESET, EN_SCLK, eval_done, eval_start, out_valid, busy, sample_drop, eval_err;
  logic [7:0]  Input_01, Input_02, eval_x, eval_a, eval_b, eval_c, eval_d, eval_mu;
  logic [47:0] FOU_UP, FOU_LOW;
  logic [5:0]  Ativo_UP;

  int   checks = 0, errors = 0;
  int   dly = 1;
  bit   skip3 = 1'b0, inj = 1'b0;
  logic pend = 1'b0;
  int   cnt = 0;
  logic [39:0] op1, op13;
  bit   err1;

  fuzz_eval_sequencer dut (
    .clk(clk), .RESET(RESET), .EN_SCLK(EN_SCLK), .Input_01(Input_01), .Input_02(Input_02),
    .eval_start(eval_start), .eval_x(eval_x), .eval_a(eval_a), .eval_b(eval_b),
    .eval_c(eval_c), .eval_d(eval_d), .eval_done(eval_done), .eval_mu(eval_mu),
    .FOU_UP(FOU_UP), .FOU_LOW(FOU_LOW), .Ativo_UP(Ativo_UP), .out_valid(out_valid),
    .busy(busy), .sample_drop(sample_drop), .eval_err(eval_err));

  always #5 clk = ~clk;

  function automatic logic [7:0] trap(input int x, input int a, input int b, input int c, input int d);
    if (x <= a || x >= d) return 8'd0;
    if (x < b) return 8'((x - a) * 255 / (b - a));
    if (x <= c) return 8'd255;
    return 8'((d - x) * 255 / (d - c));
  endfunction

  // Evaluator answers dly cycles after the start pulse; skip3 silences entry 3 (corners 18/77).
  always @(posedge clk) begin
    if (eval_start) begin pend <= 1'b1; cnt <= dly - 1; end
    else if (pend && cnt > 0) cnt <= cnt - 1;
    else pend <= 1'b0;
  end
  assign eval_done = (pend && cnt == 0 && !(skip3 && eval_a == 8'd18 && eval_b == 8'd77)) || inj;
  assign eval_mu   = inj ? 8'd99 : trap(int'(eval_x), int'(eval_a), int'(eval_b), int'(eval_c), int'(eval_d));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input logic [7:0] i1, input logic [7:0] i2, input bit inj1,
                         output int lat, output bit stable);
    logic [39:0] ops, cur;
    ops = '0; lat = 0; stable = 1'b1;
    @(negedge clk); Input_01 = i1; Input_02 = i2; EN_SCLK = 1'b1;
    @(posedge clk); #1 EN_SCLK = 1'b0; Input_01 = 8'hAA; Input_02 = 8'h55;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      inj = inj1 && (n == 1);
      cur = {eval_x, eval_a, eval_b, eval_c, eval_d};
      if (n == 1) begin op1 = cur; err1 = eval_err; end
      if (n == 13) op13 = cur;
      if (eval_start) ops = cur;
      else if (busy && !out_valid && cur !== ops) stable = 1'b0;
      if (out_valid) begin lat = n; break; end
    end
    inj = 1'b0;
  endtask

  initial begin
    int lat, drops, nv;
    bit stable, v25, b26, d26, b27;
    logic [39:0] cur;
    RESET = 1'b0; EN_SCLK = 1'b0; Input_01 = 8'd0; Input_02 = 8'd0;
    #1;
    chk("rst_fou_up", FOU_UP, 0);
    chk("rst_fou_low", FOU_LOW, 0);
    chk("rst_ativo", Ativo_UP, 0);
    chk("rst_ctrl", {out_valid, busy, sample_drop, eval_err, eval_start}, 0);
    chk("rst_ops", {eval_x, eval_a, eval_b, eval_c, eval_d}, 0);
    #20 @(negedge clk) RESET = 1'b1;

    // done strobe in IDLE must be ignored
    @(negedge clk) inj = 1'b1;
    @(negedge clk) inj = 1'b0;
    chk("idle_done_busy", {busy, out_valid}, 0);
    chk("idle_done_fou", FOU_UP, 0);

    // nominal run, with a stray done during the first ISSUE
    run_seq(8'd25, 8'd200, 1'b1, lat, stable);
    chk("t1_k0_ops", op1, {8'd25, 8'd0, 8'd1, 8'd51, 8'd114});
    chk("t1_k6_ops", op13, {8'd200, 8'd0, 8'd1, 8'd77, 8'd148});
    chk("t1_latency", lat, 25);
    chk("t1_fou_up", FOU_UP, 48'h9BB3_0000_46FF);
    chk("t1_fou_low", FOU_LOW, 48'h839F_0000_1EFF);
    chk("t1_ativo", Ativo_UP, 6'b110011);
    chk("t1_err", eval_err, 0);
    repeat (5) @(negedge clk);
    chk("t1_hold", {out_valid, busy, FOU_UP}, {2'b00, 48'h9BB3_0000_46FF});

    // slow evaluator, different operands
    dly = 5;
    run_seq(8'd60, 8'd100, 1'b0, lat, stable);
    chk("t2_latency", lat, 73);
    chk("t2_stable", stable, 1);
    chk("t2_fou_up", FOU_UP, 48'h00F7_AC00_C2DA);
    chk("t2_fou_low", FOU_LOW, 48'h00F5_9600_B5D6);
    chk("t2_ativo", Ativo_UP, 6'b110110);
    chk("t2_err", eval_err, 0);

    // entry 3 never answers: timeout after 16 WAIT cycles
    dly = 1; skip3 = 1'b1;
    run_seq(8'd25, 8'd200, 1'b0, lat, stable);
    skip3 = 1'b0;
    chk("t3_latency", lat, 40);
    chk("t3_fou_low", FOU_LOW, 48'h839F_0000_00FF);
    chk("t3_fou_up", FOU_UP, 48'h9BB3_0000_46FF);
    chk("t3_err", eval_err, 1);
    chk("t3_stable", stable, 1);

    // strobe held high for 30 cycles
    @(negedge clk); Input_01 = 8'd25; Input_02 = 8'd200; EN_SCLK = 1'b1;
    @(posedge clk);
    drops = 0; v25 = 0; b26 = 1; d26 = 1; b27 = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) err1 = eval_err;
      if (n <= 25) drops += int'(sample_drop);
      if (n == 25) v25 = out_valid;
      if (n == 26) begin b26 = busy; d26 = sample_drop; end
      if (n == 27) b27 = busy;
    end
    EN_SCLK = 1'b0;
    lat = 0;
    for (int n = 31; n <= 120; n++) begin
      @(negedge clk);
      if (out_valid) begin lat = n; break; end
    end
    chk("t4_err_cleared", err1, 0);
    chk("t4_drops", drops, 25);
    chk("t4_valid25", v25, 1);
    chk("t4_idle26", {b26, d26}, 0);
    chk("t4_restart27", b27, 1);
    chk("t4_second_valid", lat, 51);

    // reset while k = 7 is outstanding
    @(negedge clk); Input_01 = 8'd25; Input_02 = 8'd200; EN_SCLK = 1'b1;
    @(posedge clk); #1 EN_SCLK = 1'b0;
    repeat (16) @(negedge clk);
    cur = {eval_x, eval_a, eval_b, eval_c, eval_d};
    chk("t5_k7_ops", cur, {8'd200, 8'd0, 8'd1, 8'd77, 8'd133});
    RESET = 1'b0;
    #1;
    chk("t5_rst_ctrl", {busy, out_valid, eval_start, eval_err, sample_drop}, 0);
    chk("t5_rst_fou", {FOU_UP, FOU_LOW}, 0);
    chk("t5_rst_ativo_ops", {Ativo_UP, eval_x, eval_d}, 0);
    @(negedge clk) RESET = 1'b1;
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      nv += int'(out_valid);
    end
    chk("t5_no_valid", nv, 0);
    run_seq(8'd60, 8'd100, 1'b0, lat, stable);
    chk("t5_latency", lat, 25);
    chk("t5_fou", {FOU_UP, FOU_LOW}, {48'h00F7_AC00_C2DA, 48'h00F5_9600_B5D6});
    chk("t5_ativo", Ativo_UP, 6'b110110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
